// File: rtl/sha512_pkg.sv
// Shared SHA-512 definitions: initial hash values, round constants, chunk
// geometry and the message feeder state encoding.
package sha512_pkg;

  localparam int CHUNK_BYTES = 128;
  localparam int LEN_OFFSET  = 112;

  localparam logic [63:0] SHA512_IV [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [63:0] SHA512_K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_LEN,
    S_RUN,
    S_WAIT,
    S_UPDATE,
    S_OUT
  } feeder_state_t;

  // IV packed as {H0..H7}, H0 in the top 64 bits.
  function automatic logic [511:0] iv_flat();
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[511-64*i -: 64] = SHA512_IV[i];
    return r;
  endfunction

endpackage

// File: rtl/sha512_chunk_buf.sv
// 128-byte chunk buffer with an auto-incrementing byte write pointer.
// Byte j lives at data[1023-8j -: 8]. A separate port writes the 16-byte
// length field (bytes 112..127 = data[127:0]) in one cycle.
// Ports: clk, reset (async, active high), clr (zero buffer and pointer),
//        wr_en/wr_data (write byte at ptr, then ptr++), len_en/len_data,
//        ptr (current write pointer), data (flat 1024-bit read port).
module sha512_chunk_buf
  import sha512_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       len_en,
  input  logic [127:0]               len_data,
  output logic [6:0]                 ptr,
  output logic [CHUNK_BYTES*8-1:0]   data
);

  // Byte j sits at bit offset 8*(127-j); for a 7-bit j that is {~j, 3'b000}.
  logic [9:0] wr_lsb;
  assign wr_lsb = {~ptr, 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      ptr  <= '0;
    end else if (clr) begin
      data <= '0;
      ptr  <= '0;
    end else begin
      if (wr_en) begin
        data[wr_lsb +: 8] <= wr_data;
        ptr               <= ptr + 7'd1;
      end
      if (len_en) data[127:0] <= len_data;
    end
  end

endmodule

// File: rtl/sha512_msg_feeder.sv
// SHA-512 message feeder: takes a byte stream, pads it, hands 1024-bit
// chunks to one compression core, chains the intermediate hash and
// presents the final digest.
// Ports: clk, reset (async, active high); byte input in_valid/in_ready/
//        in_data/in_last/in_empty; core side core_start/core_chunk/core_H/
//        core_done/core_oH; result digest/digest_valid/digest_ack.
//
// state  | meaning
// IDLE   | load IV, clear counter and chunk buffer
// FILL   | accept message bytes into the chunk
// PAD    | write 0x80 once, then zeros
// LEN    | write 128-bit bit length into bytes 112..127
// RUN    | one cycle with core held in reset, chunk/H stable
// WAIT   | core running; wait for core_done
// UPDATE | capture core_oH as new H, clear chunk buffer
// OUT    | digest valid until digest_ack
module sha512_msg_feeder
  import sha512_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  input  logic           in_last,
  input  logic           in_empty,
  output logic           core_start,
  output logic [1023:0]  core_chunk,
  output logic [511:0]   core_H,
  input  logic           core_done,
  input  logic [511:0]   core_oH,
  output logic [511:0]   digest,
  output logic           digest_valid,
  input  logic           digest_ack
);

  feeder_state_t state_q, state_d;

  logic [LEN_W-1:0] cnt_q;
  logic [511:0]     h_q;
  logic             msg_end_q, pad_done_q, final_q, in_ready_q;
  logic [511:0]     digest_q;
  logic             digest_valid_q;

  logic             accept;
  logic             buf_clr, buf_wr, len_en;
  logic [7:0]       buf_wdata;
  logic             cnt_inc, msg_end_set, pad_set, final_set;
  logic [6:0]       ptr;
  logic [127:0]     len_bits;

  assign accept   = in_valid & in_ready_q;
  assign len_bits = 128'({cnt_q, 3'b000});

  sha512_chunk_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .wr_en    (buf_wr),
    .wr_data  (buf_wdata),
    .len_en   (len_en),
    .len_data (len_bits),
    .ptr      (ptr),
    .data     (core_chunk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;
    buf_wdata   = 8'h00;
    len_en      = 1'b0;
    cnt_inc     = 1'b0;
    msg_end_set = 1'b0;
    pad_set     = 1'b0;
    final_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        buf_clr = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (accept) begin
          if (in_last && in_empty) begin
            msg_end_set = 1'b1;
            state_d     = S_PAD;
          end else begin
            buf_wr    = 1'b1;
            buf_wdata = in_data;
            cnt_inc   = 1'b1;
            // A full chunk takes priority; the end of message is remembered
            // so padding starts in the next chunk.
            if (ptr == 7'(CHUNK_BYTES - 1)) begin
              msg_end_set = in_last;
              state_d     = S_RUN;
            end else if (in_last) begin
              msg_end_set = 1'b1;
              state_d     = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        buf_wr    = 1'b1;
        buf_wdata = pad_done_q ? 8'h00 : 8'h80;
        pad_set   = 1'b1;
        if (ptr == 7'(LEN_OFFSET - 1))       state_d = S_LEN;
        else if (ptr == 7'(CHUNK_BYTES - 1)) state_d = S_RUN;
      end
      S_LEN: begin
        len_en    = 1'b1;
        final_set = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN:  state_d = S_WAIT;
      S_WAIT: if (core_done) state_d = S_UPDATE;
      S_UPDATE: begin
        buf_clr = 1'b1;
        if (final_q)        state_d = S_OUT;
        else if (msg_end_q) state_d = S_PAD;
        else                state_d = S_FILL;
      end
      S_OUT:  if (digest_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q            <= iv_flat();
      cnt_q          <= '0;
      msg_end_q      <= 1'b0;
      pad_done_q     <= 1'b0;
      final_q        <= 1'b0;
      in_ready_q     <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      // Registered ready: high exactly while the FSM sits in FILL.
      in_ready_q <= (state_d == S_FILL);
      if (state_q == S_IDLE) begin
        h_q        <= iv_flat();
        cnt_q      <= '0;
        msg_end_q  <= 1'b0;
        pad_done_q <= 1'b0;
        final_q    <= 1'b0;
      end else begin
        if (cnt_inc)     cnt_q      <= cnt_q + LEN_W'(1);
        if (msg_end_set) msg_end_q  <= 1'b1;
        if (pad_set)     pad_done_q <= 1'b1;
        if (final_set)   final_q    <= 1'b1;
      end
      if (state_q == S_UPDATE) begin
        h_q <= core_oH;
        if (final_q) begin
          digest_q       <= core_oH;
          digest_valid_q <= 1'b1;
        end
      end
      if (state_q == S_OUT && digest_ack) digest_valid_q <= 1'b0;
    end
  end

  // Core is released from reset only while a chunk is being compressed.
  assign core_start   = (state_q != S_WAIT);
  assign core_H       = h_q;
  assign in_ready     = in_ready_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

endmodule
